// File: rtl/issue_scoreboard_pkg.sv
// Shared types and defaults for the in-order multi-issue scoreboard.
package issue_scoreboard_pkg;

  localparam int DEF_ISSUE_WIDTH = 2;
  localparam int DEF_PIPE_DEPTH  = 3;
  localparam int REG_W           = 5;
  // Stage fields in the tracking entry are stored at a fixed width so the
  // struct does not depend on the PIPE_DEPTH parameter (covers up to 16 stages).
  localparam int STG_MAX_W       = 4;

  typedef enum logic [STG_MAX_W-1:0] {
    STG_EX = 4'd0,
    STG_M1 = 4'd1,
    STG_M2 = 4'd2
  } stage_e;

  typedef struct packed {
    logic                 valid;
    logic [REG_W-1:0]     w_reg;
    logic [STG_MAX_W-1:0] ready_stage;
  } prod_entry_t;

endpackage

// File: rtl/issue_scoreboard_hazard_check.sv
// Producer lookup and RAW test for one source operand against the tracking array.
module issue_hazard_check
  import issue_scoreboard_pkg::*;
#(
  parameter int W  = DEF_ISSUE_WIDTH,
  parameter int D  = DEF_PIPE_DEPTH,
  parameter int SW = 2,
  parameter int PW = 1
) (
  input  prod_entry_t [W-1:0][D-1:0] trk_i,
  input  logic [REG_W-1:0]           r_reg_i,
  input  logic [SW-1:0]              use_stage_i,
  output logic                       found_o,
  output logic [PW-1:0]              pipe_o,
  output logic [SW-1:0]              stage_o,
  output logic                       hazard_o
);

  int src_s;
  int rdy;

  // Youngest producer wins: scan stages from EX outward, first match sticks.
  always_comb begin
    found_o = 1'b0;
    pipe_o  = '0;
    src_s   = 0;
    rdy     = 0;
    for (int s = 0; s < D; s++) begin
      for (int p = 0; p < W; p++) begin
        if (!found_o && (r_reg_i != '0) && trk_i[p][s].valid &&
            (trk_i[p][s].w_reg == r_reg_i)) begin
          found_o = 1'b1;
          pipe_o  = PW'(p);
          src_s   = s;
          rdy     = int'(trk_i[p][s].ready_stage);
        end
      end
    end
    // At the consumer's EX the producer has advanced one stage.
    stage_o  = SW'(src_s + 1);
    hazard_o = found_o && ((src_s + 1 + int'(use_stage_i)) < rdy);
  end

endmodule

// File: rtl/issue_scoreboard.sv
// In-order multi-issue controller: prefix issue, pipe placement, per-stage
// producer tracking with forwarding-source reporting, stall hold and flush.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int ISSUE_WIDTH = DEF_ISSUE_WIDTH,
  parameter int PIPE_DEPTH  = DEF_PIPE_DEPTH,
  parameter int SW          = $clog2(PIPE_DEPTH),
  parameter int PW          = (ISSUE_WIDTH > 1) ? $clog2(ISSUE_WIDTH) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [ISSUE_WIDTH-1:0]                inst_valid_i,
  input  logic [ISSUE_WIDTH-1:0][1:0][4:0]      r_reg_i,
  input  logic [ISSUE_WIDTH-1:0][4:0]           w_reg_i,
  input  logic [ISSUE_WIDTH-1:0][1:0][SW-1:0]   use_stage_i,
  input  logic [ISSUE_WIDTH-1:0][SW-1:0]        ready_stage_i,
  input  logic [ISSUE_WIDTH-1:0]                special_i,
  input  logic                                  stall_i,
  input  logic                                  flush_i,
  output logic [ISSUE_WIDTH-1:0]                issue_o,
  output logic [ISSUE_WIDTH-1:0][PW-1:0]        pipe_sel_o,
  output logic [ISSUE_WIDTH-1:0][1:0]           fwd_valid_o,
  output logic [ISSUE_WIDTH-1:0][1:0][PW-1:0]   fwd_pipe_o,
  output logic [ISSUE_WIDTH-1:0][1:0][SW-1:0]   fwd_stage_o
);

  localparam int W = ISSUE_WIDTH;
  localparam int D = PIPE_DEPTH;

  prod_entry_t [W-1:0][D-1:0] trk_q, trk_d;

  logic [W-1:0][1:0]          fwd_valid_q, fwd_valid_d;
  logic [W-1:0][1:0][PW-1:0]  fwd_pipe_q,  fwd_pipe_d;
  logic [W-1:0][1:0][SW-1:0]  fwd_stage_q, fwd_stage_d;

  logic [W-1:0][1:0]          hz_found;
  logic [W-1:0][1:0]          hz_hazard;
  logic [W-1:0][1:0][PW-1:0]  hz_pipe;
  logic [W-1:0][1:0][SW-1:0]  hz_stage;

  logic [W-1:0]               blocked;
  logic [W-1:0]               placeable;
  logic [W-1:0][PW-1:0]       pipe_sel;
  logic [W-1:0]               pipe_used;
  logic                       spec_seen;
  logic                       got_pipe;
  logic [W-1:0]               issue;
  logic                       prev_ok;
  logic                       cur_ok;

  for (genvar gi = 0; gi < W; gi++) begin : g_slot
    for (genvar gk = 0; gk < 2; gk++) begin : g_op
      issue_hazard_check #(
        .W  (W),
        .D  (D),
        .SW (SW),
        .PW (PW)
      ) u_chk (
        .trk_i       (trk_q),
        .r_reg_i     (r_reg_i[gi][gk]),
        .use_stage_i (use_stage_i[gi][gk]),
        .found_o     (hz_found[gi][gk]),
        .pipe_o      (hz_pipe[gi][gk]),
        .stage_o     (hz_stage[gi][gk]),
        .hazard_o    (hz_hazard[gi][gk])
      );
    end
  end

  // A slot is blocked by any earlier slot whose destination it reads or rewrites.
  always_comb begin
    blocked = '0;
    for (int i = 0; i < W; i++) begin
      for (int j = 0; j < i; j++) begin
        if ((w_reg_i[j] != '0) &&
            ((w_reg_i[j] == r_reg_i[i][0]) ||
             (w_reg_i[j] == r_reg_i[i][1]) ||
             (w_reg_i[j] == w_reg_i[i]))) begin
          blocked[i] = 1'b1;
        end
      end
    end
  end

  // Placement assumes every earlier slot issued; a later slot only matters
  // when that holds, since issue is a prefix.
  always_comb begin
    pipe_used = '0;
    spec_seen = 1'b0;
    got_pipe  = 1'b0;
    placeable = '0;
    pipe_sel  = '0;
    for (int i = 0; i < W; i++) begin
      got_pipe = 1'b0;
      if (special_i[i]) begin
        placeable[i] = !spec_seen && !pipe_used[0];
        pipe_sel[i]  = '0;
        pipe_used[0] = 1'b1;
        spec_seen    = 1'b1;
      end else begin
        for (int p = 1; p < W; p++) begin
          if (!got_pipe && !pipe_used[p]) begin
            got_pipe     = 1'b1;
            pipe_sel[i]  = PW'(p);
            pipe_used[p] = 1'b1;
          end
        end
        if (!got_pipe && !pipe_used[0]) begin
          got_pipe     = 1'b1;
          pipe_sel[i]  = '0;
          pipe_used[0] = 1'b1;
        end
        placeable[i] = got_pipe;
      end
    end
  end

  // Thermometer issue mask, suppressed entirely on stall, flush or reset.
  always_comb begin
    issue   = '0;
    prev_ok = !(stall_i || flush_i || rst);
    cur_ok  = 1'b0;
    for (int i = 0; i < W; i++) begin
      cur_ok   = prev_ok && inst_valid_i[i] && !hz_hazard[i][0] && !hz_hazard[i][1] &&
                 !blocked[i] && placeable[i];
      issue[i] = cur_ok;
      prev_ok  = cur_ok;
    end
  end

  // Tracking array: shift one stage per unstalled cycle, load issued
  // instructions into stage 0 of their pipe; flush clears even under stall.
  always_comb begin
    trk_d = trk_q;
    if (flush_i) begin
      trk_d = '0;
    end else if (!stall_i) begin
      for (int p = 0; p < W; p++) begin
        for (int s = D - 1; s >= 1; s--) begin
          trk_d[p][s] = trk_q[p][s-1];
        end
        trk_d[p][0] = '0;
        for (int i = 0; i < W; i++) begin
          if (issue[i] && (pipe_sel[i] == PW'(p))) begin
            trk_d[p][0].valid       = 1'b1;
            trk_d[p][0].w_reg       = w_reg_i[i];
            trk_d[p][0].ready_stage = STG_MAX_W'(ready_stage_i[i]);
          end
        end
      end
    end
  end

  // Forwarding source for the instructions issued this cycle, held on stall.
  always_comb begin
    fwd_valid_d = fwd_valid_q;
    fwd_pipe_d  = fwd_pipe_q;
    fwd_stage_d = fwd_stage_q;
    if (flush_i) begin
      fwd_valid_d = '0;
    end else if (!stall_i) begin
      for (int i = 0; i < W; i++) begin
        for (int k = 0; k < 2; k++) begin
          fwd_valid_d[i][k] = issue[i] && hz_found[i][k];
          fwd_pipe_d[i][k]  = fwd_valid_d[i][k] ? hz_pipe[i][k]  : '0;
          fwd_stage_d[i][k] = fwd_valid_d[i][k] ? hz_stage[i][k] : '0;
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      trk_q       <= '0;
      fwd_valid_q <= '0;
      fwd_pipe_q  <= '0;
      fwd_stage_q <= '0;
    end else begin
      trk_q       <= trk_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_pipe_q  <= fwd_pipe_d;
      fwd_stage_q <= fwd_stage_d;
    end
  end

  assign issue_o     = issue;
  assign pipe_sel_o  = pipe_sel;
  assign fwd_valid_o = fwd_valid_q;
  assign fwd_pipe_o  = fwd_pipe_q;
  assign fwd_stage_o = fwd_stage_q;

endmodule
